// File: rtl/soil_moisture_scheduler.sv
// Averages 4 gated moisture samples and issues a one-cycle irrigation request when dry; latency 2 clocks from 4th sample.
// No backpressure: samples outside SAMPLE or while gated are dropped; ack timeout sets sticky fault and proceeds to cooldown.
module soil_moisture_scheduler #(
    parameter logic [7:0] DRY_THRESHOLD = 8'd80,
    parameter logic [3:0] MAX_TIME      = 4'd15,
    parameter int         ACK_TIMEOUT   = 16,
    parameter int         COOLDOWN      = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       moisture_valid,
    input  logic [7:0] moisture_data,
    input  logic       sensor_enable,
    input  logic       watering_in_progress,
    output logic [3:0] irrigation_time,
    output logic [7:0] avg_moisture,
    output logic       busy,
    output logic       fault
);

    localparam int CNT_MAX = (ACK_TIMEOUT > COOLDOWN) ? ACK_TIMEOUT : COOLDOWN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_SAMPLE,
        ST_EVAL,
        ST_REQUEST,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_COOLDOWN
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [9:0]         acc;
    logic [1:0]         count;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic               ack_expired;
    logic               cool_done;
    logic [7:0]         eval_avg;
    logic               is_dry;
    logic [7:0]         deficit;
    logic [7:0]         t_raw;
    logic [3:0]         t_req;

    logic [3:0]         irrigation_time_d;
    logic               busy_d;
    logic               avg_load;
    logic               fault_set;

    assign accept      = (state == ST_SAMPLE) && moisture_valid && sensor_enable && !watering_in_progress;
    assign ack_expired = (cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign cool_done   = (cnt == CNT_W'(COOLDOWN - 1));

    // Deficit is only formed when dry, so the 8-bit subtraction never wraps.
    assign eval_avg = acc[9:2];
    assign is_dry   = (eval_avg < DRY_THRESHOLD);
    assign deficit  = is_dry ? (DRY_THRESHOLD - eval_avg) : 8'd0;
    assign t_raw    = (deficit >> 3) + 8'd1;
    assign t_req    = (t_raw > {4'd0, MAX_TIME}) ? MAX_TIME : t_raw[3:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_SAMPLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_SAMPLE: begin
                if (watering_in_progress) begin
                    next_state = ST_WAIT_DONE;
                end else if (accept && (count == 2'd3)) begin
                    next_state = ST_EVAL;
                end
            end
            ST_EVAL:       next_state = is_dry ? ST_REQUEST : ST_SAMPLE;
            ST_REQUEST:    next_state = ST_WAIT_START;
            ST_WAIT_START: begin
                if (watering_in_progress) begin
                    next_state = ST_WAIT_DONE;
                end else if (ack_expired) begin
                    next_state = ST_COOLDOWN;
                end
            end
            ST_WAIT_DONE: begin
                if (!watering_in_progress) begin
                    next_state = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                if (cool_done) begin
                    next_state = ST_SAMPLE;
                end
            end
            default:       next_state = ST_SAMPLE;
        endcase
    end

    // Output next-values decode from next_state so the registered outputs line up with the state they describe.
    always_comb begin
        irrigation_time_d = 4'd0;
        busy_d            = (next_state != ST_SAMPLE);
        avg_load          = (state == ST_EVAL);
        fault_set         = (state == ST_WAIT_START) && !watering_in_progress && ack_expired;
        if (next_state == ST_REQUEST) begin
            irrigation_time_d = t_req;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irrigation_time <= 4'd0;
            avg_moisture    <= 8'd0;
            busy            <= 1'b0;
            fault           <= 1'b0;
        end else begin
            irrigation_time <= irrigation_time_d;
            busy            <= busy_d;
            if (avg_load) begin
                avg_moisture <= eval_avg;
            end
            if (fault_set) begin
                fault <= 1'b1;
            end
        end
    end

    // External watering in SAMPLE throws away the partial window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= 10'd0;
            count <= 2'd0;
        end else if ((state == ST_SAMPLE) && watering_in_progress) begin
            acc   <= 10'd0;
            count <= 2'd0;
        end else if (accept) begin
            acc   <= acc + {2'b00, moisture_data};
            count <= count + 2'd1;
        end else if (state == ST_EVAL) begin
            acc   <= 10'd0;
            count <= 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= '0;
        end else if ((state == ST_WAIT_START) || (state == ST_COOLDOWN)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_soil_moisture_scheduler.sv
// Bench for soil_moisture_scheduler: directed scenarios plus randomized windows against a queue-based reference model.
module tb_soil_moisture_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       moisture_valid = 1'b0;
    logic [7:0] moisture_data = 8'd0;
    logic       sensor_enable = 1'b1;
    logic       watering_in_progress = 1'b0;
    logic       hi_en = 1'b0;

    logic [3:0] irrigation_time;
    logic [7:0] avg_moisture;
    logic       busy;
    logic       fault;

    logic       hi_valid;
    logic       hi_wip;
    logic [3:0] hi_irrigation_time;
    logic [7:0] hi_avg_moisture;
    logic       hi_busy;
    logic       hi_fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign hi_valid = moisture_valid & hi_en;
    assign hi_wip   = watering_in_progress & hi_en;

    soil_moisture_scheduler dut (
        .clk                  (clk),
        .reset                (reset),
        .moisture_valid       (moisture_valid),
        .moisture_data        (moisture_data),
        .sensor_enable        (sensor_enable),
        .watering_in_progress (watering_in_progress),
        .irrigation_time      (irrigation_time),
        .avg_moisture         (avg_moisture),
        .busy                 (busy),
        .fault                (fault)
    );

    soil_moisture_scheduler #(.DRY_THRESHOLD(8'd200)) dut_hi (
        .clk                  (clk),
        .reset                (reset),
        .moisture_valid       (hi_valid),
        .moisture_data        (moisture_data),
        .sensor_enable        (sensor_enable),
        .watering_in_progress (hi_wip),
        .irrigation_time      (hi_irrigation_time),
        .avg_moisture         (hi_avg_moisture),
        .busy                 (hi_busy),
        .fault                (hi_fault)
    );

    // Reference: requested time from the averaging rule, 0 meaning "no request".
    function automatic int ref_time(input int avg, input int thr);
        int t;
        if (avg >= thr) return 0;
        t = ((thr - avg) / 8) + 1;
        return (t > 15) ? 15 : t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic en);
        moisture_valid = v;
        moisture_data  = d;
        sensor_enable  = en;
        tick();
        moisture_valid = 1'b0;
        sensor_enable  = 1'b1;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = -1;
        for (int i = 0; i < 200; i++) begin
            if (busy === 1'b0) begin
                cycles = i;
                break;
            end
            tick();
        end
    endtask

    // Called while in REQUEST: acknowledges, holds watering, releases and waits for return to SAMPLE.
    task automatic run_watering(input int hold, output int idle_cycles);
        watering_in_progress = 1'b1;
        tick();
        tick();
        repeat (hold) tick();
        watering_in_progress = 1'b0;
        wait_idle(idle_cycles);
    endtask

    task automatic test_reset();
        checks++; if (irrigation_time !== 4'd0) begin errors++; $display("FAIL reset_time: got %0d expected 0", irrigation_time); end
        checks++; if (avg_moisture !== 8'd0) begin errors++; $display("FAIL reset_avg: got %0d expected 0", avg_moisture); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b expected 0", fault); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_dry();
        int idle;
        repeat (4) drive(1'b1, 8'd40, 1'b1);
        checks++; if (irrigation_time !== 4'd0) begin errors++; $display("FAIL dry_early: got %0d expected 0", irrigation_time); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dry_busy_eval: got %0b expected 1", busy); end
        tick();
        checks++; if (irrigation_time !== 4'd6) begin errors++; $display("FAIL dry_time: got %0d expected 6", irrigation_time); end
        checks++; if (avg_moisture !== 8'd40) begin errors++; $display("FAIL dry_avg: got %0d expected 40", avg_moisture); end
        watering_in_progress = 1'b1;
        tick();
        checks++; if (irrigation_time !== 4'd0) begin errors++; $display("FAIL dry_pulse_width: got %0d expected 0", irrigation_time); end
        tick();
        repeat (3) tick();
        watering_in_progress = 1'b0;
        wait_idle(idle);
        checks++; if (idle < 30 || idle > 40) begin errors++; $display("FAIL dry_return: got %0d cycles expected 30..40", idle); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL dry_fault: got %0b expected 0", fault); end
    endtask

    task automatic test_wet();
        drive(1'b1, 8'd200, 1'b1);
        drive(1'b1, 8'd190, 1'b1);
        drive(1'b1, 8'd210, 1'b1);
        drive(1'b1, 8'd200, 1'b1);
        tick();
        checks++; if (avg_moisture !== 8'd200) begin errors++; $display("FAIL wet_avg: got %0d expected 200", avg_moisture); end
        checks++; if (irrigation_time !== 4'd0) begin errors++; $display("FAIL wet_time: got %0d expected 0", irrigation_time); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wet_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_saturation();
        int idle;
        hi_en = 1'b1;
        repeat (4) drive(1'b1, 8'd0, 1'b1);
        tick();
        checks++; if (irrigation_time !== 4'd11) begin errors++; $display("FAIL sat_time80: got %0d expected 11", irrigation_time); end
        checks++; if (hi_irrigation_time !== 4'd15) begin errors++; $display("FAIL sat_time200: got %0d expected 15", hi_irrigation_time); end
        checks++; if (hi_avg_moisture !== 8'd0) begin errors++; $display("FAIL sat_avg200: got %0d expected 0", hi_avg_moisture); end
        run_watering(2, idle);
        checks++; if (idle < 0 || hi_busy !== 1'b0) begin errors++; $display("FAIL sat_return: got idle=%0d hi_busy=%0b expected idle>=0 hi_busy=0", idle, hi_busy); end
        hi_en = 1'b0;
    endtask

    task automatic test_gating();
        int idle;
        drive(1'b1, 8'd79, 1'b1);
        drive(1'b1, 8'd5, 1'b0);
        drive(1'b1, 8'd79, 1'b1);
        drive(1'b0, 8'd0, 1'b1);
        drive(1'b1, 8'd250, 1'b0);
        drive(1'b1, 8'd79, 1'b1);
        drive(1'b1, 8'd0, 1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_early_eval: got busy=%0b expected 0", busy); end
        drive(1'b1, 8'd79, 1'b1);
        tick();
        checks++; if (avg_moisture !== 8'd79) begin errors++; $display("FAIL gate_avg: got %0d expected 79", avg_moisture); end
        checks++; if (irrigation_time !== 4'd1) begin errors++; $display("FAIL gate_time: got %0d expected 1", irrigation_time); end
        run_watering(1, idle);
        checks++; if (idle < 0) begin errors++; $display("FAIL gate_return: got timeout expected idle"); end
    endtask

    task automatic test_external();
        int idle;
        int pulses = 0;
        drive(1'b1, 8'd10, 1'b1);
        drive(1'b1, 8'd10, 1'b1);
        watering_in_progress = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ext_busy: got %0b expected 1", busy); end
        for (int i = 0; i < 4; i++) begin
            if (irrigation_time !== 4'd0) pulses++;
            tick();
        end
        watering_in_progress = 1'b0;
        wait_idle(idle);
        checks++; if (idle < 0 || pulses != 0) begin errors++; $display("FAIL ext_return: got idle=%0d pulses=%0d expected idle>=0 pulses=0", idle, pulses); end
        repeat (4) drive(1'b1, 8'd100, 1'b1);
        tick();
        checks++; if (avg_moisture !== 8'd100) begin errors++; $display("FAIL ext_fresh_avg: got %0d expected 100", avg_moisture); end
    endtask

    task automatic test_handshake_timeout();
        int idle;
        repeat (4) drive(1'b1, 8'd40, 1'b1);
        tick();
        for (int i = 1; i <= 49; i++) begin
            moisture_valid = (i >= 20 && i <= 45);
            moisture_data  = 8'd0;
            tick();
            if (i == 16) begin
                checks++; if (fault !== 1'b0) begin errors++; $display("FAIL to_fault_early: got %0b expected 0", fault); end
            end
            if (i == 17) begin
                checks++; if (fault !== 1'b1) begin errors++; $display("FAIL to_fault: got %0b expected 1", fault); end
            end
            if (i == 48) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_cooldown_len: got busy=%0b expected 1", busy); end
            end
            if (i == 49) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_sample: got busy=%0b expected 0", busy); end
            end
        end
        moisture_valid = 1'b0;
        repeat (4) drive(1'b1, 8'd120, 1'b1);
        tick();
        checks++; if (avg_moisture !== 8'd120) begin errors++; $display("FAIL to_cool_drop: got %0d expected 120", avg_moisture); end
        repeat (4) drive(1'b1, 8'd20, 1'b1);
        tick();
        checks++; if (irrigation_time !== 4'd8) begin errors++; $display("FAIL sticky_time: got %0d expected 8", irrigation_time); end
        run_watering(2, idle);
        checks++; if (fault !== 1'b1 || idle < 0) begin errors++; $display("FAIL sticky_fault: got fault=%0b idle=%0d expected fault=1 idle>=0", fault, idle); end
    endtask

    task automatic test_random();
        int q[$];
        int base, v, sum, exp_avg, exp_t, idle;
        logic vv, en;
        for (int w = 0; w < 14; w++) begin
            q.delete();
            base = $urandom_range(0, 255);
            while (q.size() < 4) begin
                vv = ($urandom_range(0, 4) != 0);
                en = ($urandom_range(0, 3) != 0);
                v  = base + int'($urandom_range(0, 40)) - 20;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                if (vv && en) q.push_back(v);
                drive(vv, 8'(v), en);
            end
            sum = 0;
            foreach (q[i]) sum += q[i];
            exp_avg = sum / 4;
            exp_t   = ref_time(exp_avg, 80);
            tick();
            checks++; if (avg_moisture !== 8'(exp_avg)) begin errors++; $display("FAIL rnd_avg w%0d: got %0d expected %0d", w, avg_moisture, exp_avg); end
            checks++; if (irrigation_time !== 4'(exp_t)) begin errors++; $display("FAIL rnd_time w%0d: got %0d expected %0d", w, irrigation_time, exp_t); end
            if (exp_t != 0) begin
                run_watering(int'($urandom_range(0, 5)), idle);
                checks++; if (idle < 0) begin errors++; $display("FAIL rnd_return w%0d: got timeout expected idle", w); end
            end else begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_wet_busy w%0d: got %0b expected 0", w, busy); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int busy_seen = 0;
        repeat (4) drive(1'b1, 8'd40, 1'b1);
        tick();
        watering_in_progress = 1'b1;
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        checks++; if (irrigation_time !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_wd_outputs: got time=%0d busy=%0b expected 0 0", irrigation_time, busy); end
        checks++; if (avg_moisture !== 8'd0 || fault !== 1'b0) begin errors++; $display("FAIL rst_wd_regs: got avg=%0d fault=%0b expected 0 0", avg_moisture, fault); end
        watering_in_progress = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (irrigation_time !== 4'd0) pulses++;
            if (busy !== 1'b0) busy_seen++;
        end
        checks++; if (pulses != 0 || busy_seen != 0) begin errors++; $display("FAIL rst_no_pulse: got pulses=%0d busy=%0d expected 0 0", pulses, busy_seen); end
        drive(1'b1, 8'd60, 1'b1);
        drive(1'b1, 8'd60, 1'b1);
        moisture_valid = 1'b1;
        moisture_data  = 8'd200;
        #3;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || irrigation_time !== 4'd0) begin errors++; $display("FAIL rst_s3_outputs: got busy=%0b time=%0d expected 0 0", busy, irrigation_time); end
        tick();
        moisture_valid = 1'b0;
        reset = 1'b1;
        tick();
        drive(1'b1, 8'd100, 1'b1);
        drive(1'b1, 8'd100, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_s3_window: got busy=%0b expected 0", busy); end
        drive(1'b1, 8'd100, 1'b1);
        drive(1'b1, 8'd100, 1'b1);
        tick();
        checks++; if (avg_moisture !== 8'd100) begin errors++; $display("FAIL rst_s3_avg: got %0d expected 100", avg_moisture); end
    endtask

    initial begin
        #3;
        test_reset();
        test_dry();
        test_wet();
        test_saturation();
        test_gating();
        test_external();
        test_handshake_timeout();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/soil_moisture_scheduler.md
SOIL_MOISTURE_SCHEDULER -- requirements
Module: soil_moisture_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- DRY_THRESHOLD, 8'd80: average below this is "dry".
- MAX_TIME, 4'd15: ceiling on the requested irrigation time.
- ACK_TIMEOUT, 16: cycles to wait for watering_in_progress to rise.
- COOLDOWN, 32: settle cycles after watering ends, before sampling resumes.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line, clock and reset first:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low.
- moisture_valid, in, 1: moisture_data valid this cycle.
- moisture_data, in, 8: soil moisture sample; 0 = dry, 255 = saturated.
- sensor_enable, in, 1: from the downstream irrigation controller; sampling permitted.
- watering_in_progress, in, 1: from the downstream irrigation controller.
- irrigation_time, out, 4: request to downstream; nonzero for exactly one cycle.
- avg_moisture, out, 8: last computed 4-sample average.
- busy, out, 1: high in any state other than SAMPLE.
- fault, out, 1: sticky ack-timeout flag.

Function
REQ-003 The FSM SHALL have exactly six states: SAMPLE, EVAL, REQUEST, WAIT_START, WAIT_DONE, COOLDOWN.

REQ-004 In SAMPLE, a sample SHALL be accepted only when moisture_valid=1, sensor_enable=1 and watering_in_progress=0; otherwise the sample is dropped and the count is unchanged.

REQ-005 Accepted samples SHALL be summed into a 10-bit accumulator with a 2-bit count; the 4th accepted sample SHALL move the FSM to EVAL on the next edge.

REQ-006 In EVAL (one cycle), the block SHALL:
- set avg_moisture = accumulator[9:2] (truncating divide by 4);
- clear the accumulator and the count.

REQ-007 In EVAL, if avg_moisture < DRY_THRESHOLD, the block SHALL go to REQUEST; otherwise it SHALL return to SAMPLE.

REQ-008 The requested time SHALL be t = ((DRY_THRESHOLD - avg) >> 3) + 1, saturated to MAX_TIME, computed at 8-bit width with no wrap; t is never 0.

REQ-009 In REQUEST (one cycle), irrigation_time SHALL equal t; in every other state, irrigation_time SHALL be 0. The next state SHALL be WAIT_START.

REQ-010 WAIT_START SHALL behave as follows:
- it counts cycles;
- watering_in_progress=1 moves the FSM to WAIT_DONE;
- if ACK_TIMEOUT cycles pass without it, fault is set and the FSM goes to COOLDOWN.

REQ-011 WAIT_DONE SHALL stay until watering_in_progress=0, then go to COOLDOWN.

REQ-012 COOLDOWN SHALL count COOLDOWN cycles, then go to SAMPLE; samples arriving in COOLDOWN SHALL be dropped.

REQ-013 If watering_in_progress rises while in SAMPLE (externally triggered watering), the block SHALL:
- discard the partial accumulation;
- go to WAIT_DONE.

REQ-014 fault SHALL remain set until reset; operation SHALL continue normally while fault=1.

REQ-015 busy SHALL be a registered decode of state != SAMPLE.

REQ-016 All outputs SHALL be registered; irrigation_time SHALL appear the cycle after EVAL (latency: 4th sample edge -> EVAL -> REQUEST output = 2 clocks).

Reset
REQ-017 On reset=0, regardless of clk, the block SHALL immediately:
- set state = SAMPLE;
- clear accumulator, count and all counters;
- drive irrigation_time=0, avg_moisture=0, busy=0, fault=0.

REQ-018 Reset asserted mid-operation (any state) SHALL abort with no further request pulse; operation SHALL resume in SAMPLE on the first rising clk edge after reset=1.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Dry: samples 40,40,40,40, sensor_enable=1 -> avg_moisture=40; irrigation_time=6 for one cycle, 2 clocks after the 4th sample.
- Wet: samples 200,190,210,200 -> avg_moisture=200, no request, state back in SAMPLE, busy=0.
- Saturation: samples 0,0,0,0 -> t=11; with DRY_THRESHOLD=200, t saturates to 15.
- Gating: samples with sensor_enable=0 interleaved -> ignored; only 4 accepted samples trigger EVAL; avg 79 at DRY_THRESHOLD=80 -> t=1.
- Handshake: request issued, watering_in_progress never rises -> fault=1 after 16 cycles, then COOLDOWN 32 cycles, then SAMPLE; a normal handshake runs WAIT_DONE then COOLDOWN with fault=0.
- Reset: reset=0 during WAIT_DONE and during the 3rd sample -> outputs zero immediately, no pulse, fresh 4-sample window after release.
